alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command front-end for the registered-output ALU (decoder + arith/logic/CMP/shift units).
//  Buffers {func, A, B} commands in a FIFO and issues one at a time to the ALU.
//  Captures the result of the selected unit and returns it on a valid/ready response port.
//  Sits between a bus/host master and alu_top; it is the only driver of ALU_FUNC, A and B.
// PARAMETERS
//  A_WIDTH     16  operand A width (matches alu_top A_WIDTH_TOP)
//  B_WIDTH     16  operand B width (matches alu_top B_WIDTH_TOP)
//  FIFO_DEPTH  4   command FIFO entries; power of 2, >=2
// PORTS
//  CLK             in   1              clock, rising edge
//  rst             in   1              asynchronous, active-high reset
//  cmd_valid       in   1              command offered
//  cmd_ready       out  1              FIFO can accept (= !full)
//  cmd_func        in   4              ALU function; [3:2] unit select, [1:0] op
//  cmd_a           in   A_WIDTH        operand A
//  cmd_b           in   B_WIDTH        operand B
//  alu_func        out  4              to alu_top ALU_FUNC (registered)
//  alu_a           out  A_WIDTH        to alu_top A (registered)
//  alu_b           out  B_WIDTH        to alu_top B (registered)
//  alu_arith_out   in   A_WIDTH+B_WIDTH  from Arith_OUT; likewise alu_logic_out, alu_cmp_out, alu_shift_out
//  alu_carry       in   1              from Carry_OUT
//  alu_arith_flag  in   1              from Arith_Flag; likewise alu_logic_flag, alu_cmp_flag, alu_shift_flag
//  rsp_valid       out  1              response held valid
//  rsp_ready       in   1              response consumed
//  rsp_data        out  A_WIDTH+B_WIDTH  selected unit result
//  rsp_unit        out  2              unit that produced rsp_data (copy of func[3:2])
//  rsp_carry       out  1              alu_carry for arith unit, 0 otherwise
//  rsp_err         out  1              selected unit flag was low at capture
//  busy            out  1              state != IDLE or FIFO not empty
// BEHAVIOUR
//  Reset (async): FIFO empty; state IDLE; all outputs 0 (alu_func=4'b0000); cmd_ready=1 once rst is low.
//  FIFO: push on cmd_valid&cmd_ready. cmd_ready depends only on registered full, not on same-cycle pop.
//   Pop only from a registered non-empty count, so a push into an empty FIFO pops on the next edge.
//   Commands are issued strictly in order; pointers wrap modulo FIFO_DEPTH.
//  FSM IDLE -> EXEC -> CAPT -> RESP:
//   IDLE: if !empty: pop, load alu_func/alu_a/alu_b, go to EXEC.
//   EXEC: ALU sees stable operands; the ALU registers its outputs at the end of the cycle; go to CAPT.
//   CAPT: unit=alu_func[3:2] (00 arith, 01 logic, 10 cmp, 11 shift).
//    Register rsp_data from that unit's output, rsp_carry, and rsp_err=~that unit's flag.
//    Set rsp_valid=1 and go to RESP.
//   RESP: hold all rsp_* stable while !rsp_ready. On rsp_ready:
//    if !empty: pop and load the next command, go to EXEC (rsp_valid drops for exactly 2 cycles).
//    else: go to IDLE, rsp_valid=0.
//  alu_func/alu_a/alu_b change only on a pop edge; otherwise they hold the last issued command.
//  Latency: accepted at edge N -> popped edge N+1 -> rsp_valid high after edge N+3.
//   Sustained throughput: 1 response per 3 cycles with rsp_ready tied high.
//  Capacity: 1 in flight + FIFO_DEPTH buffered.
//  Reset mid-operation discards FIFO contents and the in-flight command; no response is produced for them.
// TESTING
//  Reset: rst pulse mid-clock -> all outputs 0 immediately; cmd_ready=1 after release; busy=0.
//  Single add: func=4'b0000, A=5, B=3 accepted at edge 0 -> rsp_valid after edge 3.
//   Expect rsp_data=8, rsp_unit=0, rsp_err=0.
//  Backpressure/full (DEPTH=4): rsp_ready=0, 6 back-to-back commands -> 5 accepted, cmd_ready=0.
//   rsp_data stays stable; releasing rsp_ready returns all 5 in order, with rsp_valid gaps of 2 cycles.
//  Unit routing: one command per unit (func 0000, 0100, 1000, 1100).
//   Expect rsp_unit 0..3, each rsp_data equal to that unit's output; rsp_carry=0 for non-arith.
//  Flag error: stub ALU holds the selected flag low -> rsp_err=1 and rsp_data still captured.
//  Reset mid-op: assert rst while in EXEC with 3 queued commands.
//   Expect FIFO empty, no rsp_valid afterwards, busy=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command front-end for a registered-output ALU. Host commands {func, A, B} are buffered
// in a small FIFO and issued one at a time. The result of the unit selected by func[3:2]
// is captured and returned on a valid/ready response port.
// Ports:
//   i_clk, i_rst                    clock (rising edge), asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready         command handshake; i_cmd_func/i_cmd_a/i_cmd_b payload
//   o_alu_func/o_alu_a/o_alu_b      registered operands driven to the ALU
//   i_alu_*_out, i_alu_carry,
//   i_alu_*_flag                    ALU unit results and flags
//   o_rsp_valid/i_rsp_ready         response handshake
//   o_rsp_data/unit/carry/err       captured result, producing unit, carry, flag-low error
//   o_busy                          sequencer active or commands queued
module alu_cmd_sequencer #(
   parameter int unsigned A_WIDTH    = 16,
   parameter int unsigned B_WIDTH    = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_cmd_valid,
   output logic                       o_cmd_ready,
   input  logic [3:0]                 i_cmd_func,
   input  logic [A_WIDTH-1:0]         i_cmd_a,
   input  logic [B_WIDTH-1:0]         i_cmd_b,
   output logic [3:0]                 o_alu_func,
   output logic [A_WIDTH-1:0]         o_alu_a,
   output logic [B_WIDTH-1:0]         o_alu_b,
   input  logic [A_WIDTH+B_WIDTH-1:0] i_alu_arith_out,
   input  logic [A_WIDTH+B_WIDTH-1:0] i_alu_logic_out,
   input  logic [A_WIDTH+B_WIDTH-1:0] i_alu_cmp_out,
   input  logic [A_WIDTH+B_WIDTH-1:0] i_alu_shift_out,
   input  logic                       i_alu_carry,
   input  logic                       i_alu_arith_flag,
   input  logic                       i_alu_logic_flag,
   input  logic                       i_alu_cmp_flag,
   input  logic                       i_alu_shift_flag,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [A_WIDTH+B_WIDTH-1:0] o_rsp_data,
   output logic [1:0]                 o_rsp_unit,
   output logic                       o_rsp_carry,
   output logic                       o_rsp_err,
   output logic                       o_busy
);

   localparam int unsigned RW    = A_WIDTH + B_WIDTH;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned CMD_W = 4 + RW;

   typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

   state_e             r_state;
   logic [CMD_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [3:0]         r_alu_func;
   logic [A_WIDTH-1:0] r_alu_a;
   logic [B_WIDTH-1:0] r_alu_b;
   logic               r_rsp_valid;
   logic [RW-1:0]      r_rsp_data;
   logic [1:0]         r_rsp_unit;
   logic               r_rsp_carry;
   logic               r_rsp_err;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic [CMD_W-1:0]   w_head;
   logic [RW-1:0]      w_sel_data;
   logic               w_sel_flag;
   logic               w_sel_carry;

   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   // Ready comes from the registered count only; held low while reset is asserted.
   assign o_cmd_ready = ~w_full & ~i_rst;
   assign w_push      = i_cmd_valid & o_cmd_ready;
   assign w_pop       = ~w_empty &
                        ((r_state == StIdle) | ((r_state == StResp) & i_rsp_ready));
   assign w_head      = r_mem[r_rd_ptr];

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {i_cmd_func, i_cmd_a, i_cmd_b};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Result selection by the unit field of the command currently at the ALU.
   always_comb begin
      w_sel_data = i_alu_arith_out;
      w_sel_flag = i_alu_arith_flag;
      unique case (r_alu_func[3:2])
         2'b00: begin w_sel_data = i_alu_arith_out; w_sel_flag = i_alu_arith_flag; end
         2'b01: begin w_sel_data = i_alu_logic_out; w_sel_flag = i_alu_logic_flag; end
         2'b10: begin w_sel_data = i_alu_cmp_out;   w_sel_flag = i_alu_cmp_flag;   end
         2'b11: begin w_sel_data = i_alu_shift_out; w_sel_flag = i_alu_shift_flag; end
      endcase
   end

   assign w_sel_carry = (r_alu_func[3:2] == 2'b00) ? i_alu_carry : 1'b0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_alu_func  <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_unit  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_pop) begin
                  r_alu_func <= w_head[CMD_W-1 -: 4];
                  r_alu_a    <= w_head[RW-1 -: A_WIDTH];
                  r_alu_b    <= w_head[B_WIDTH-1:0];
                  r_state    <= StExec;
               end
            end
            // ALU registers its outputs at the end of this cycle.
            StExec: r_state <= StCapt;
            StCapt: begin
               r_rsp_data  <= w_sel_data;
               r_rsp_unit  <= r_alu_func[3:2];
               r_rsp_carry <= w_sel_carry;
               r_rsp_err   <= ~w_sel_flag;
               r_rsp_valid <= 1'b1;
               r_state     <= StResp;
            end
            StResp: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  if (w_pop) begin
                     r_alu_func <= w_head[CMD_W-1 -: 4];
                     r_alu_a    <= w_head[RW-1 -: A_WIDTH];
                     r_alu_b    <= w_head[B_WIDTH-1:0];
                     r_state    <= StExec;
                  end else begin
                     r_state <= StIdle;
                  end
               end
            end
         endcase
      end
   end

   assign o_alu_func  = r_alu_func;
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_unit  = r_rsp_unit;
   assign o_rsp_carry = r_rsp_carry;
   assign o_rsp_err   = r_rsp_err;
   assign o_busy      = (r_state != StIdle) | ~w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer. A behavioural ALU stub registers per-unit
// results from the operands the DUT drives; expected responses come from a queue of
// per-command results computed directly from {func, A, B}.
module tb_alu_cmd_sequencer;

   localparam int AW = 16;
   localparam int BW = 16;
   localparam int RW = AW + BW;

   typedef struct packed {
      logic [RW-1:0] data;
      logic [1:0]    unit;
      logic          carry;
      logic          err;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [3:0]    cmd_func = '0;
   logic [AW-1:0] cmd_a = '0;
   logic [BW-1:0] cmd_b = '0;
   logic [3:0]    alu_func;
   logic [AW-1:0] alu_a;
   logic [BW-1:0] alu_b;
   logic [RW-1:0] arith_out = '0;
   logic [RW-1:0] logic_out = '0;
   logic [RW-1:0] cmp_out = '0;
   logic [RW-1:0] shift_out = '0;
   logic          carry = 1'b0;
   logic [3:0]    flags = 4'hF;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [RW-1:0] rsp_data;
   logic [1:0]    rsp_unit;
   logic          rsp_carry;
   logic          rsp_err;
   logic          busy;

   logic [3:0]    flag_low = 4'h0;
   rsp_t          exp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.A_WIDTH(AW), .B_WIDTH(BW), .FIFO_DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_func(cmd_func), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
      .o_alu_func(alu_func), .o_alu_a(alu_a), .o_alu_b(alu_b),
      .i_alu_arith_out(arith_out), .i_alu_logic_out(logic_out),
      .i_alu_cmp_out(cmp_out), .i_alu_shift_out(shift_out),
      .i_alu_carry(carry),
      .i_alu_arith_flag(flags[0]), .i_alu_logic_flag(flags[1]),
      .i_alu_cmp_flag(flags[2]), .i_alu_shift_flag(flags[3]),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(rsp_data), .o_rsp_unit(rsp_unit),
      .o_rsp_carry(rsp_carry), .o_rsp_err(rsp_err), .o_busy(busy)
   );

   // What each ALU unit computes for a given op and operand pair.
   function automatic logic [RW-1:0] unit_out(input logic [1:0] u, input logic [1:0] op,
                                              input logic [AW-1:0] a, input logic [BW-1:0] b);
      logic [RW-1:0] a32;
      logic [RW-1:0] b32;
      a32 = {16'b0, a};
      b32 = {16'b0, b};
      case (u)
         2'd0: case (op)
            2'd0: return a32 + b32;
            2'd1: return a32 - b32;
            2'd2: return a32 * b32;
            default: return {a, b};
         endcase
         2'd1: case (op)
            2'd0: return a32 & b32;
            2'd1: return a32 | b32;
            2'd2: return a32 ^ b32;
            default: return {16'b0, ~(a & b)};
         endcase
         2'd2: case (op)
            2'd0: return {31'b0, a == b};
            2'd1: return {31'b0, a > b};
            2'd2: return {31'b0, a < b};
            default: return {31'b0, a != b};
         endcase
         default: case (op)
            2'd0: return a32 << b[3:0];
            2'd1: return a32 >> b[3:0];
            2'd2: return {a, a} >> b[3:0];
            default: return a32 << 1;
         endcase
      endcase
   endfunction

   function automatic rsp_t expect_rsp(input logic [3:0] f, input logic [AW-1:0] a,
                                       input logic [BW-1:0] b);
      rsp_t r;
      logic [AW:0] s;
      s       = {1'b0, a} + {1'b0, b};
      r.data  = unit_out(f[3:2], f[1:0], a, b);
      r.unit  = f[3:2];
      r.carry = (f[3:2] == 2'd0) ? s[AW] : 1'b0;
      r.err   = flag_low[f[3:2]];
      return r;
   endfunction

   function automatic rsp_t dut_rsp();
      return '{rsp_data, rsp_unit, rsp_carry, rsp_err};
   endfunction

   // Registered-output ALU stub.
   logic [AW:0] stub_sum;
   assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b};
   always @(posedge clk) begin
      arith_out <= unit_out(2'd0, alu_func[1:0], alu_a, alu_b);
      logic_out <= unit_out(2'd1, alu_func[1:0], alu_a, alu_b);
      cmp_out   <= unit_out(2'd2, alu_func[1:0], alu_a, alu_b);
      shift_out <= unit_out(2'd3, alu_func[1:0], alu_a, alu_b);
      carry     <= stub_sum[AW];
      flags     <= ~flag_low;
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push_cmd(input logic [3:0] f, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, output bit ok);
      cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b; ok = 1'b0;
      for (int t = 0; t < 400 && !ok; t++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            exp_q.push_back(expect_rsp(f, a, b));
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
   endtask

   // Waits for rsp_valid, samples it, then consumes it with a one-cycle rsp_ready pulse.
   task automatic recv_rsp(input int budget, output bit ok, output rsp_t got, output int waited);
      ok = 1'b0; waited = 0; got = '0;
      for (int t = 0; t < budget; t++) begin
         if (rsp_valid) begin
            ok = 1'b1; got = dut_rsp(); waited = t;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bit ok;
      n_cmp++;
      if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
         n_bad++; $display("FAIL reset_init: got %b expected 100", {cmd_ready, busy, rsp_valid});
      end
      rsp_ready = 1'b0;
      push_cmd(4'b0001, 16'd7, 16'd2, ok);
      for (int t = 0; t < 10 && !rsp_valid; t++) @(negedge clk);
      n_cmp++;
      if (!rsp_valid || rsp_data !== 32'd5) begin
         n_bad++; $display("FAIL reset_pre: got valid=%b data=%h expected 1/5", rsp_valid, rsp_data);
      end
      @(posedge clk); #3 rst = 1'b1; #1;
      n_cmp++;
      if ({alu_func, alu_a, alu_b} !== '0) begin
         n_bad++; $display("FAIL reset_alu: got %h expected 0", {alu_func, alu_a, alu_b});
      end
      n_cmp++;
      if (dut_rsp() !== '0 || rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_rsp: got %h valid=%b expected 0", dut_rsp(), rsp_valid);
      end
      n_cmp++;
      if ({cmd_ready, busy} !== 2'b00) begin
         n_bad++; $display("FAIL reset_status: got %b expected 00", {cmd_ready, busy});
      end
      @(negedge clk); #2 rst = 1'b0; #1;
      n_cmp++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_bad++; $display("FAIL reset_release: got %b expected 10", {cmd_ready, busy});
      end
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_single_add();
      bit ok; rsp_t got; int waited;
      push_cmd(4'b0000, 16'd5, 16'd3, ok);
      recv_rsp(20, ok, got, waited);
      n_cmp++;
      if (!ok || waited != 3) begin
         n_bad++; $display("FAIL add_latency: got ok=%b edges=%0d expected 3", ok, waited);
      end
      n_cmp++;
      if (got !== rsp_t'{32'd8, 2'd0, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL add_result: got %h expected data=8 unit=0 err=0", got);
      end
      void'(exp_q.pop_front());
      n_cmp++;
      if ({alu_func, alu_a, alu_b} !== {4'b0000, 16'd5, 16'd3}) begin
         n_bad++; $display("FAIL add_alu_hold: got %h expected 0_0005_0003", {alu_func, alu_a, alu_b});
      end
   endtask

   task automatic test_backpressure();
      int acc; bit ok; rsp_t got; int waited; logic [3:0] f; logic [AW-1:0] a; logic [BW-1:0] b;
      rsp_ready = 1'b0; acc = 0;
      for (int i = 0; i < 6; i++) begin
         f = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
         cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b;
         if (cmd_ready) begin acc++; exp_q.push_back(expect_rsp(f, a, b)); end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      n_cmp++;
      if (acc != 5 || cmd_ready !== 1'b0) begin
         n_bad++; $display("FAIL bp_accept: got %0d ready=%b expected 5 ready=0", acc, cmd_ready);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (!rsp_valid || dut_rsp() !== exp_q[0]) begin
            n_bad++; $display("FAIL bp_hold: got v=%b %h expected %h", rsp_valid, dut_rsp(), exp_q[0]);
         end
         @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         recv_rsp(20, ok, got, waited);
         n_cmp++;
         if (!ok || exp_q.size() == 0 || got !== exp_q[0]) begin
            n_bad++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got,
                              (exp_q.size() != 0) ? exp_q[0] : rsp_t'('0));
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (i > 0) begin
            n_cmp++;
            if (waited != 2) begin
               n_bad++; $display("FAIL bp_gap[%0d]: got %0d expected 2", i, waited);
            end
         end
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, rsp_valid} !== 2'b00) begin
         n_bad++; $display("FAIL bp_drain: got %b expected 00", {busy, rsp_valid});
      end
   endtask

   task automatic test_unit_routing();
      bit ok; rsp_t got; int waited;
      for (int u = 0; u < 4; u++) begin
         push_cmd({2'(u), 2'b00}, 16'hFFFF, 16'h0001, ok);
         recv_rsp(20, ok, got, waited);
         n_cmp++;
         if (!ok || got !== exp_q[0]) begin
            n_bad++; $display("FAIL route_u%0d: got %h expected %h", u, got, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      n_cmp++;
      if ({alu_func, alu_a} !== {4'b1100, 16'hFFFF}) begin
         n_bad++; $display("FAIL route_hold: got %h expected c_ffff", {alu_func, alu_a});
      end
   endtask

   task automatic test_flag_err();
      bit ok; rsp_t got; int waited; logic [1:0] u2;
      for (int u = 0; u < 4; u++) begin
         flag_low = 4'(1 << u);
         repeat (2) @(negedge clk);
         u2 = 2'(u + 1);
         push_cmd({2'(u), 2'($urandom)}, 16'($urandom), 16'($urandom), ok);
         push_cmd({u2, 2'($urandom)}, 16'($urandom), 16'($urandom), ok);
         for (int k = 0; k < 2; k++) begin
            recv_rsp(20, ok, got, waited);
            n_cmp++;
            if (!ok || got !== exp_q[0]) begin
               n_bad++; $display("FAIL flag_u%0d_%0d: got %h expected %h", u, k, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
      flag_low = 4'h0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      int got_n; bit held; rsp_t hold_v; rsp_t cur;
      flag_low = 4'($urandom);
      repeat (2) @(negedge clk);
      got_n = 0; held = 1'b0; hold_v = '0;
      fork
         begin
            bit ok;
            for (int i = 0; i < 40; i++) begin
               push_cmd(4'($urandom), 16'($urandom), 16'($urandom), ok);
               n_cmp++;
               if (!ok) begin n_bad++; $display("FAIL rand_push[%0d]: got stuck expected accept", i); end
               repeat ($urandom_range(0, 2)) @(negedge clk);
            end
         end
         begin
            for (int t = 0; t < 3000 && got_n < 40; t++) begin
               cur = dut_rsp();
               if (held) begin
                  n_cmp++;
                  if (!rsp_valid || cur !== hold_v) begin
                     n_bad++; $display("FAIL rand_hold: got v=%b %h expected %h", rsp_valid, cur, hold_v);
                  end
               end
               held = 1'b0;
               rsp_ready = 1'($urandom_range(0, 1));
               if (rsp_valid) begin
                  if (rsp_ready) begin
                     n_cmp++;
                     if (exp_q.size() == 0 || cur !== exp_q[0]) begin
                        n_bad++; $display("FAIL rand_rsp[%0d]: got %h expected %h", got_n, cur,
                                          (exp_q.size() != 0) ? exp_q[0] : rsp_t'('0));
                     end
                     if (exp_q.size() != 0) void'(exp_q.pop_front());
                     got_n++;
                  end else begin
                     held = 1'b1; hold_v = cur;
                  end
               end
               @(negedge clk);
            end
         end
      join
      rsp_ready = 1'b0;
      n_cmp++;
      if (got_n != 40) begin n_bad++; $display("FAIL rand_count: got %0d expected 40", got_n); end
      flag_low = 4'h0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      bit ok; rsp_t got; int waited; int seen;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_cmd(4'($urandom), 16'($urandom), 16'($urandom), ok);
      for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp++;
      if ({busy, rsp_valid} !== 2'b10) begin
         n_bad++; $display("FAIL midrst_pre: got %b expected 10", {busy, rsp_valid});
      end
      #2 rst = 1'b1; #1;
      n_cmp++;
      if ({busy, rsp_valid, cmd_ready} !== 3'b000) begin
         n_bad++; $display("FAIL midrst_assert: got %b expected 000", {busy, rsp_valid, cmd_ready});
      end
      #4 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      seen = 0;
      for (int t = 0; t < 20; t++) begin
         if (rsp_valid) seen++;
         @(negedge clk);
      end
      n_cmp++;
      if (seen != 0 || {busy, cmd_ready} !== 2'b01) begin
         n_bad++; $display("FAIL midrst_after: got valid_cycles=%0d busy/ready=%b expected 0/01",
                           seen, {busy, cmd_ready});
      end
      push_cmd(4'b0110, 16'h00F0, 16'h0F0F, ok);
      recv_rsp(20, ok, got, waited);
      n_cmp++;
      if (!ok || got !== exp_q[0]) begin
         n_bad++; $display("FAIL midrst_fresh: got %h expected %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_add();
      test_backpressure();
      test_unit_routing();
      test_flag_err();
      test_random();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
